fp_norm_round: RTL and testbench

Normalize-and-round stage of the single-precision floating-point adder/subtracter. It sits directly downstream of the 32-bit leading-one priority encoder. It consumes the raw post-add mantissa together with the encoder's leading-one position (`Dout`) and `Valid`. It shifts the mantissa into normalized form, adjusts the exponent, rounds, and packs an IEEE-754 single-precision result. It is a two-stage pipeline with valid/ready handshakes on both sides.

---
 rtl/fp_norm_round.sv | 156 +++++++++++++++
 tb/tb_fp_norm_round.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_norm_round.sv
// Normalize-and-round stage of the single-precision adder: two-stage valid/ready pipeline.
// Optional macro FP_NORM_RNE_EN selects round-to-nearest-even; otherwise results are truncated.
module fp_norm_round (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        In_valid,
  output logic        In_ready,
  input  logic        In_sign,
  input  logic [7:0]  In_exp,
  input  logic [27:0] In_mant,
  input  logic [4:0]  In_lead,
  input  logic        In_nz,
  output logic        Out_valid,
  input  logic        Out_ready,
  output logic [31:0] Out_result,
  output logic [3:0]  Out_flags
);

  typedef enum logic [1:0] {ClsNorm, ClsZero, ClsUflow, ClsSpecial} cls_e;

  logic              w_s1_adv;
  logic              w_s2_adv;
  logic              r_s1_valid;
  logic              r_s1_sign;
  logic              r_s1_nan;
  cls_e              r_s1_cls;
  logic signed [9:0] r_s1_exp;
  logic [26:0]       r_s1_mant;
  logic              r_s2_valid;
  logic [31:0]       r_s2_result;
  logic [3:0]        r_s2_flags;

  assign w_s2_adv   = !r_s2_valid || Out_ready;
  assign w_s1_adv   = !r_s1_valid || w_s2_adv;
  assign In_ready   = w_s1_adv;
  assign Out_valid  = r_s2_valid;
  assign Out_result = r_s2_result;
  assign Out_flags  = r_s2_flags;

  // Stage 1: normalize so the leading one lands on bit 26 (hidden bit).
  logic [4:0]        w_shamt;
  logic [26:0]       w_norm_mant;
  logic signed [9:0] w_norm_exp;
  logic              w_nan;
  cls_e              w_cls;

  always_comb begin
    w_shamt     = 5'd0;
    w_norm_mant = In_mant[26:0];
    w_norm_exp  = $signed({2'b00, In_exp});
    if (In_lead >= 5'd27) begin
      w_norm_mant = {In_mant[27:2], In_mant[1] | In_mant[0]};
      w_norm_exp  = $signed({2'b00, In_exp}) + 10'sd1;
    end else if (In_lead < 5'd26) begin
      w_shamt     = 5'd26 - In_lead;
      w_norm_mant = In_mant[26:0] << w_shamt;
      w_norm_exp  = $signed({2'b00, In_exp}) - $signed({5'b00000, w_shamt});
    end
    w_nan = |In_mant[25:3];
    if (In_exp == 8'hFF) begin
      w_cls = ClsSpecial;
    end else if (!In_nz) begin
      w_cls = ClsZero;
    end else if (w_norm_exp <= 10'sd0) begin
      w_cls = ClsUflow;
    end else begin
      w_cls = ClsNorm;
    end
  end

  // Stage 2: round on G/R/S, then pack.
  logic              w_g;
  logic              w_r;
  logic              w_s;
  logic              w_inexact;
  logic              w_inc;
  logic [24:0]       w_sum;
  logic [22:0]       w_frac;
  logic signed [9:0] w_exp_fin;
  logic [31:0]       w_result;
  logic [3:0]        w_flags;

  always_comb begin
    w_g       = r_s1_mant[2];
    w_r       = r_s1_mant[1];
    w_s       = r_s1_mant[0];
    w_inexact = w_g | w_r | w_s;
`ifdef FP_NORM_RNE_EN
    w_inc     = w_g & (w_r | w_s | r_s1_mant[3]);
`else
    w_inc     = 1'b0;
`endif
    w_sum     = {1'b0, r_s1_mant[26:3]} + {24'd0, w_inc};
    w_frac    = w_sum[24] ? 23'd0 : w_sum[22:0];
    w_exp_fin = r_s1_exp + $signed({9'd0, w_sum[24]});
    w_result  = 32'h0;
    w_flags   = 4'h0;
    case (r_s1_cls)
      ClsZero: begin
        w_result = 32'h0;
      end
      ClsUflow: begin
        w_result   = {r_s1_sign, 31'd0};
        w_flags[2] = 1'b1;
        w_flags[1] = 1'b1;
      end
      ClsSpecial: begin
        w_result = r_s1_nan ? 32'h7FC0_0000 : {r_s1_sign, 8'hFF, 23'd0};
      end
      default: begin
        if (w_exp_fin >= 10'sd255) begin
          w_result   = {r_s1_sign, 8'hFF, 23'd0};
          w_flags[3] = 1'b1;
          w_flags[1] = 1'b1;
        end else begin
          w_result   = {r_s1_sign, w_exp_fin[7:0], w_frac};
          w_flags[1] = w_inexact;
        end
      end
    endcase
    w_flags[0] = (w_result[30:0] == 31'd0);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_sign   <= 1'b0;
      r_s1_nan    <= 1'b0;
      r_s1_cls    <= ClsNorm;
      r_s1_exp    <= 10'sd0;
      r_s1_mant   <= 27'd0;
      r_s2_valid  <= 1'b0;
      r_s2_result <= 32'h0;
      r_s2_flags  <= 4'h0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= In_valid;
      end
      if (w_s1_adv && In_valid) begin
        r_s1_sign <= In_sign;
        r_s1_nan  <= w_nan;
        r_s1_cls  <= w_cls;
        r_s1_exp  <= w_norm_exp;
        r_s1_mant <= w_norm_mant;
      end
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
      end
      if (w_s2_adv && r_s1_valid) begin
        r_s2_result <= w_result;
        r_s2_flags  <= w_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp_norm_round.sv
// Scoreboard bench for fp_norm_round; expected words queued on acceptance, popped on output.
`timescale 1ns/1ps
module tb_fp_norm_round;

  logic        Clk;
  logic        Reset;
  logic        In_valid;
  logic        In_ready;
  logic        In_sign;
  logic [7:0]  In_exp;
  logic [27:0] In_mant;
  logic [4:0]  In_lead;
  logic        In_nz;
  logic        Out_valid;
  logic        Out_ready;
  logic [31:0] Out_result;
  logic [3:0]  Out_flags;

  fp_norm_round dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .In_valid   (In_valid),
    .In_ready   (In_ready),
    .In_sign    (In_sign),
    .In_exp     (In_exp),
    .In_mant    (In_mant),
    .In_lead    (In_lead),
    .In_nz      (In_nz),
    .Out_valid  (Out_valid),
    .Out_ready  (Out_ready),
    .Out_result (Out_result),
    .Out_flags  (Out_flags)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [27:0] m;
    logic [4:0]  l;
    logic        nz;
    logic [31:0] res;
    logic [3:0]  flg;
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  flg;
  } exp_t;

`ifdef FP_NORM_RNE_EN
  localparam logic [31:0] TieRes   = 32'h3F80_0002;
  localparam logic [31:0] CarryRes = 32'h4000_0000;
  localparam logic [31:0] ShlRes   = 32'h3E80_0002;
`else
  localparam logic [31:0] TieRes   = 32'h3F80_0001;
  localparam logic [31:0] CarryRes = 32'h3FFF_FFFF;
  localparam logic [31:0] ShlRes   = 32'h3E80_0001;
`endif

  exp_t q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_out   = 0;
  int   cyc     = 0;

  always @(posedge Clk) cyc++;

  always @(negedge Clk) begin
    if (!Reset && Out_valid && Out_ready) begin
      n_out++;
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got result=%h flags=%b, required no output",
                 Out_result, Out_flags);
      end else begin
        mon_e = q.pop_front();
        if (Out_result !== mon_e.res || Out_flags !== mon_e.flg) begin
          n_fail++;
          $display("FAIL out_word: got result=%h flags=%b, required result=%h flags=%b",
                   Out_result, Out_flags, mon_e.res, mon_e.flg);
        end
      end
    end
  end

  function automatic vec_t mk(input logic s, input logic [7:0] e, input logic [27:0] m,
                              input logic [4:0] l, input logic nz, input logic [31:0] res,
                              input logic [3:0] flg);
    vec_t v;
    v.s = s; v.e = e; v.m = m; v.l = l; v.nz = nz; v.res = res; v.flg = flg;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    In_valid = 1'b1;
    In_sign  = v.s;
    In_exp   = v.e;
    In_mant  = v.m;
    In_lead  = v.l;
    In_nz    = v.nz;
  endtask

  // Offers v until accepted; returns #1 after the accepting edge with In_valid still high.
  task automatic send(input vec_t v);
    logic rdy;
    logic done;
    exp_t e;
    done = 1'b0;
    drive(v);
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge Clk);
      rdy = In_ready;
      @(posedge Clk);
      #1;
      if (rdy) begin
        e.res = v.res;
        e.flg = v.flg;
        q.push_back(e);
        done = 1'b1;
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got no acceptance, required acceptance within 50 cycles");
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && q.size() != 0; k++) begin
      @(posedge Clk);
      #1;
    end
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d words pending, required 0", q.size());
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; In_valid = 1'b0; Out_ready = 1'b0;
    In_sign = 1'b0; In_exp = 8'd0; In_mant = 28'd0; In_lead = 5'd0; In_nz = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    n_tests++;
    if (Out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b, required 0", Out_valid);
    end
    n_tests++;
    if (Out_result !== 32'h0 || Out_flags !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h/%b, required 00000000/0000", Out_result, Out_flags);
    end
    n_tests++;
    if (In_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b, required 1", In_ready);
    end
  endtask

  task automatic test_carry_latency();
    Out_ready = 1'b1;
    send(mk(1'b0, 8'd127, 28'h8000000, 5'd27, 1'b1, 32'h4000_0000, 4'b0000));
    In_valid = 1'b0;
    n_tests++;
    if (Out_valid !== 1'b0) begin
      n_fail++; $display("FAIL lat_edge1: got Out_valid=%b, required 0", Out_valid);
    end
    @(posedge Clk);
    #1;
    n_tests++;
    if (Out_valid !== 1'b1) begin
      n_fail++; $display("FAIL lat_edge2: got Out_valid=%b, required 1", Out_valid);
    end
    drain();
  endtask

  task automatic test_normalize();
    Out_ready = 1'b1;
    send(mk(1'b0, 8'd127, 28'h0000008, 5'd3, 1'b1, 32'h3400_0000, 4'b0000));
    send(mk(1'b0, 8'd3, 28'h0000008, 5'd3, 1'b1, 32'h0000_0000, 4'b0111));
    send(mk(1'b1, 8'd1, 28'h0000010, 5'd4, 1'b1, 32'h8000_0000, 4'b0111));
    send(mk(1'b0, 8'd127, 28'h8000003, 5'd27, 1'b1, 32'h4000_0000, 4'b0010));
    send(mk(1'b0, 8'd127, 28'h1000003, 5'd24, 1'b1, ShlRes, 4'b0010));
    In_valid = 1'b0;
    drain();
  endtask

  task automatic test_rounding();
    Out_ready = 1'b1;
    send(mk(1'b0, 8'd127, 28'h400000C, 5'd26, 1'b1, TieRes, 4'b0010));
    In_valid = 1'b0;
    send(mk(1'b0, 8'd127, 28'h7FFFFFC, 5'd26, 1'b1, CarryRes, 4'b0010));
    In_valid = 1'b0;
    drain();
  endtask

  task automatic test_special();
    Out_ready = 1'b1;
    send(mk(1'b0, 8'd254, 28'h8000000, 5'd27, 1'b1, 32'h7F80_0000, 4'b1010));
    send(mk(1'b0, 8'd255, 28'h4000008, 5'd26, 1'b1, 32'h7FC0_0000, 4'b0000));
    send(mk(1'b1, 8'd255, 28'h4000000, 5'd26, 1'b1, 32'hFF80_0000, 4'b0000));
    send(mk(1'b1, 8'd100, 28'h0000000, 5'd0, 1'b0, 32'h0000_0000, 4'b0001));
    send(mk(1'b1, 8'd127, 28'h4000000, 5'd26, 1'b1, 32'hBF80_0000, 4'b0000));
    In_valid = 1'b0;
    drain();
  endtask

  task automatic test_back_to_back();
    int c0;
    int n0;
    Out_ready = 1'b1;
    n0 = n_out;
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      send(mk(i[0], 8'd120 + 8'(i), 28'h4000000 | (28'(i) << 3), 5'd26, 1'b1,
              {i[0], 8'd120 + 8'(i), 20'd0, 3'(i)}, 4'b0000));
    end
    n_tests++;
    if (cyc - c0 != 8) begin
      n_fail++; $display("FAIL b2b_rate: got %0d cycles for 8 words, required 8", cyc - c0);
    end
    In_valid = 1'b0;
    drain();
    n_tests++;
    if (n_out - n0 != 8) begin
      n_fail++; $display("FAIL b2b_count: got %0d outputs, required 8", n_out - n0);
    end
  endtask

  task automatic test_backpressure();
    vec_t v[3];
    logic rdy;
    int   acc;
    int   n0;
    logic [31:0] held;
    exp_t e;
    v[0] = mk(1'b0, 8'd130, 28'h4000000, 5'd26, 1'b1, 32'h4100_0000, 4'b0000);
    v[1] = mk(1'b1, 8'd127, 28'h400000C, 5'd26, 1'b1, {1'b1, TieRes[30:0]}, 4'b0010);
    v[2] = mk(1'b0, 8'd127, 28'h0000008, 5'd3, 1'b1, 32'h3400_0000, 4'b0000);
    Out_ready = 1'b0;
    acc = 0;
    rdy = 1'b0;
    n0 = n_out;
    for (int i = 0; i < 3; i++) begin
      drive(v[i]);
      @(negedge Clk);
      rdy = In_ready;
      @(posedge Clk);
      #1;
      if (rdy) begin
        e.res = v[i].res; e.flg = v[i].flg; q.push_back(e); acc++;
      end
    end
    n_tests++;
    if (acc != 2 || rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_accept: got %0d accepted, third ready=%b, required 2 and 0", acc, rdy);
    end
    held = Out_result;
    repeat (3) @(posedge Clk);
    #1;
    n_tests++;
    if (Out_valid !== 1'b1 || Out_result !== held || Out_result !== q[0].res) begin
      n_fail++;
      $display("FAIL bp_hold: got valid=%b result=%h, required 1 and %h",
               Out_valid, Out_result, q[0].res);
    end
    n_tests++;
    if (In_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_in_ready: got %b, required 0", In_ready);
    end
    Out_ready = 1'b1;
    send(v[2]);
    In_valid = 1'b0;
    drain();
    n_tests++;
    if (n_out - n0 != 3) begin
      n_fail++; $display("FAIL bp_count: got %0d outputs, required 3", n_out - n0);
    end
  endtask

  task automatic test_reset_flush();
    int n0;
    Out_ready = 1'b0;
    send(mk(1'b0, 8'd127, 28'h8000000, 5'd27, 1'b1, 32'h4000_0000, 4'b0000));
    send(mk(1'b0, 8'd128, 28'h4000000, 5'd26, 1'b1, 32'h4000_0000, 4'b0000));
    In_valid = 1'b0;
    n_tests++;
    if (Out_valid !== 1'b1 || In_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_full: got valid=%b in_ready=%b, required 1 and 0", Out_valid, In_ready);
    end
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    q.delete();
    n_tests++;
    if (Out_valid !== 1'b0 || Out_result !== 32'h0 || Out_flags !== 4'h0 || In_ready !== 1'b1)
    begin
      n_fail++;
      $display("FAIL flush_state: got valid=%b result=%h flags=%b in_ready=%b, required 0/0/0/1",
               Out_valid, Out_result, Out_flags, In_ready);
    end
    Out_ready = 1'b1;
    n0 = n_out;
    repeat (5) @(posedge Clk);
    #1;
    n_tests++;
    if (n_out != n0) begin
      n_fail++; $display("FAIL flush_stale: got %0d outputs, required 0", n_out - n0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_carry_latency();
    test_normalize();
    test_rounding();
    test_special();
    test_back_to_back();
    test_backpressure();
    test_reset_flush();
    n_tests++;
    if (q.size() != 0) begin
      n_fail++; $display("FAIL final_queue: got %0d pending, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
